// File: rtl/vdp_sprite_meta_dma.sv
// Sprite metadata DMA: copies x/y/g attribute tables from a
// 16-bit source memory into the sprite core, reading only in vblank.
module vdp_sprite_meta_dma (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] src_base_address,
  input  logic [8:0]  count,
  input  logic [2:0]  block_mask,
  input  logic        vblank,
  output logic        busy,
  output logic        done,
  output logic [15:0] src_read_address,
  output logic        src_read_en,
  input  logic        src_read_ack,
  input  logic [15:0] src_read_data,
  input  logic        src_data_valid,
  output logic [7:0]  meta_address,
  output logic [15:0] meta_write_data,
  output logic [2:0]  meta_block_select,
  output logic        meta_we
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [2:0]  mask_q, mask_d;
  logic [1:0]  tbl_q, tbl_d;
  logic [7:0]  n_q, n_d;
  logic [15:0] data_q, data_d;
  logic [15:0] addr_q, addr_d;
  logic        en_q, en_d;

  logic [8:0]  cnt_clamp;
  logic        last_n;

  // State register and all datapath flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      tbl_q   <= '0;
      n_q     <= '0;
      data_q  <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      tbl_q   <= tbl_d;
      n_q     <= n_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      en_q    <= en_d;
    end
  end

  // Next-state, sprite/table sequencing and registered read request
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    tbl_d     = tbl_q;
    n_d       = n_q;
    data_d    = data_q;
    cnt_clamp = (count > 9'd256) ? 9'd256 : count;
    last_n    = (({1'b0, n_q} + 9'd1) >= cnt_q);
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = src_base_address;
          cnt_d  = cnt_clamp;
          mask_d = block_mask;
          n_d    = '0;
          if (cnt_clamp == 9'd0 || block_mask == 3'b000) begin
            state_d = S_FINISH;
          end else begin
            state_d = S_REQ;
            tbl_d   = block_mask[0] ? 2'd0 :
                      block_mask[1] ? 2'd1 : 2'd2;
          end
        end
      end
      S_REQ: begin
        if (en_q && src_read_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (src_data_valid) begin
          data_d  = src_read_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!last_n) begin
          n_d     = n_q + 8'd1;
          state_d = S_REQ;
        end else if (tbl_q == 2'd0 && mask_q[1]) begin
          tbl_d   = 2'd1;
          n_d     = '0;
          state_d = S_REQ;
        end else if (tbl_q != 2'd2 && mask_q[2]) begin
          tbl_d   = 2'd2;
          n_d     = '0;
          state_d = S_REQ;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Request is registered, so it follows vblank one cycle late;
    // the address is frozen for the whole REQ stay.
    en_d   = (state_d == S_REQ) && vblank;
    addr_d = (state_d == S_REQ) ?
             base_d + {6'd0, tbl_d, n_d} : addr_q;
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_FINISH);
    meta_we           = (state_q == S_WRITE);
    meta_block_select = meta_we ? (3'b001 << tbl_q) : 3'b000;
    meta_address      = n_q;
    meta_write_data   = data_q;
    src_read_en       = en_q;
    src_read_address  = addr_q;
  end

endmodule

// File: tb/tb_vdp_sprite_meta_dma.sv
// Randomized bench for vdp_sprite_meta_dma: memory responder with
// random ack/data delays, checked against a table-walk reference model.
module tb_vdp_sprite_meta_dma;

  logic        clk = 1'b0;
  logic        reset, start, vblank;
  logic [15:0] src_base_address;
  logic [8:0]  count;
  logic [2:0]  block_mask;
  logic        busy, done;
  logic [15:0] src_read_address;
  logic        src_read_en, src_read_ack, src_data_valid;
  logic [15:0] src_read_data;
  logic [7:0]  meta_address;
  logic [15:0] meta_write_data;
  logic [2:0]  meta_block_select;
  logic        meta_we;

  vdp_sprite_meta_dma dut (
    .clk(clk), .reset(reset), .start(start),
    .src_base_address(src_base_address), .count(count),
    .block_mask(block_mask), .vblank(vblank),
    .busy(busy), .done(done),
    .src_read_address(src_read_address),
    .src_read_en(src_read_en), .src_read_ack(src_read_ack),
    .src_read_data(src_read_data),
    .src_data_valid(src_data_valid),
    .meta_address(meta_address),
    .meta_write_data(meta_write_data),
    .meta_block_select(meta_block_select),
    .meta_we(meta_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0]  sel;
    logic [7:0]  id;
    logic [15:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] salt = 16'h5A3C;

  logic [15:0] rd_q[$];
  logic [15:0] exp_rd[$];
  wr_t         wr_q[$];
  wr_t         exp_wr[$];
  int          last_wr_cyc = 0;
  int          ack_count = 0;
  int          ack_max = 0;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ salt;
  endfunction

  // Source memory: one outstanding read, random ack wait and latency
  initial begin : responder
    bit          pending;
    bit          armed;
    int          ack_wait;
    int          lat_left;
    logic [15:0] pend_addr;
    pending = 0;
    armed = 0;
    ack_wait = 0;
    lat_left = 0;
    pend_addr = '0;
    src_read_ack = 1'b0;
    src_data_valid = 1'b0;
    src_read_data = '0;
    forever begin
      @(negedge clk);
      src_read_ack = 1'b0;
      src_data_valid = 1'b0;
      src_read_data = 16'($urandom);
      if (meta_we) begin
        wr_q.push_back(wr_t'{meta_block_select, meta_address,
                             meta_write_data});
        last_wr_cyc = cyc;
      end
      if (pending) begin
        lat_left--;
        if (lat_left == 0) begin
          src_data_valid = 1'b1;
          src_read_data = memf(pend_addr);
          pending = 0;
        end
      end else if (src_read_en) begin
        if (!armed) begin
          ack_wait = int'($urandom_range(ack_max, 0));
          armed = 1;
        end
        if (ack_wait == 0) begin
          src_read_ack = 1'b1;
          rd_q.push_back(src_read_address);
          pend_addr = src_read_address;
          lat_left = int'($urandom_range(lat_max, lat_min));
          pending = 1;
          armed = 0;
          ack_count++;
        end else begin
          ack_wait--;
        end
      end
    end
  end

  // Reference model: planar tables walked x,y,g, sprites 0..n-1
  task automatic build_exp(input logic [15:0] b,
                           input logic [8:0] c,
                           input logic [2:0] m);
    int n;
    logic [15:0] a;
    exp_rd.delete();
    exp_wr.delete();
    n = (c > 9'd256) ? 256 : int'(c);
    for (int k = 0; k < 3; k++) begin
      if (m[k]) begin
        for (int i = 0; i < n; i++) begin
          a = b + 16'(k * 256 + i);
          exp_rd.push_back(a);
          exp_wr.push_back(wr_t'{3'(1 << k), 8'(i), memf(a)});
        end
      end
    end
  endtask

  function automatic int rd_diff();
    for (int i = 0; i < exp_rd.size(); i++) begin
      if (i >= rd_q.size()) return i;
      if (rd_q[i] !== exp_rd[i]) return i;
    end
    if (rd_q.size() != exp_rd.size()) return exp_rd.size();
    return -1;
  endfunction

  function automatic int wr_diff();
    for (int i = 0; i < exp_wr.size(); i++) begin
      if (i >= wr_q.size()) return i;
      if (wr_q[i] !== exp_wr[i]) return i;
    end
    if (wr_q.size() != exp_wr.size()) return exp_wr.size();
    return -1;
  endfunction

  task automatic clear_obs();
    rd_q.delete();
    wr_q.delete();
  endtask

  task automatic pulse_start(input logic [15:0] b,
                             input logic [8:0] c,
                             input logic [2:0] m);
    @(negedge clk);
    start = 1'b1;
    src_base_address = b;
    count = c;
    block_mask = m;
    @(negedge clk);
    start = 1'b0;
    src_base_address = 16'($urandom);
    count = 9'($urandom);
    block_mask = 3'($urandom);
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, src_read_en, src_read_address, meta_we,
         meta_address, meta_write_data, meta_block_select} !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b done=%b en=%b ra=%h we=%b ma=%h wd=%h sel=%b required all zero",
               busy, done, src_read_en, src_read_address, meta_we,
               meta_address, meta_write_data, meta_block_select);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dcyc, d;
    ack_max = 0; lat_min = 1; lat_max = 1;
    vblank = 1'b1;
    clear_obs();
    build_exp(16'h4000, 9'd2, 3'b111);
    pulse_start(16'h4000, 9'd2, 3'b111);
    checks++;
    if (busy !== 1'b1 || src_read_en !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: busy=%b en=%b required 1 1",
               busy, src_read_en);
    end
    wait_done(200, dcyc);
    checks++;
    if (dcyc < 0) begin
      errors++;
      $display("FAIL basic_timeout: done never seen, required done");
    end
    d = rd_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL basic_reads: idx %0d got %h (n=%0d) required %h (n=%0d)",
               d, (d < rd_q.size()) ? rd_q[d] : 16'hxxxx, rd_q.size(),
               exp_rd[d < exp_rd.size() ? d : 0], exp_rd.size());
    end
    d = wr_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL basic_writes: idx %0d got n=%0d required n=%0d",
               d, wr_q.size(), exp_wr.size());
    end
    checks++;
    if (dcyc != last_wr_cyc + 1) begin
      errors++;
      $display("FAIL basic_done_time: done cyc %0d required %0d",
               dcyc, last_wr_cyc + 1);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_at_done: busy=%b required 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: busy=%b done=%b required 0 0",
               busy, done);
    end
  endtask

  task automatic test_zero_length();
    logic [8:0] cs[2];
    logic [2:0] ms[2];
    cs[0] = 9'd0; ms[0] = 3'b111;
    cs[1] = 9'd5; ms[1] = 3'b000;
    vblank = 1'b1;
    for (int t = 0; t < 2; t++) begin
      clear_obs();
      pulse_start(16'($urandom), cs[t], ms[t]);
      checks++;
      if (busy !== 1'b1 || done !== 1'b1) begin
        errors++;
        $display("FAIL zero_t1[%0d]: busy=%b done=%b required 1 1",
                 t, busy, done);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_t2[%0d]: busy=%b done=%b required 0 0",
                 t, busy, done);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (rd_q.size() != 0 || wr_q.size() != 0) begin
        errors++;
        $display("FAIL zero_traffic[%0d]: reads=%0d writes=%0d required 0 0",
                 t, rd_q.size(), wr_q.size());
      end
    end
  endtask

  task automatic test_wrap_256();
    int dcyc, d;
    ack_max = 0; lat_min = 1; lat_max = 1;
    vblank = 1'b1;
    clear_obs();
    build_exp(16'hFE00, 9'd256, 3'b100);
    pulse_start(16'hFE00, 9'd256, 3'b100);
    wait_done(3000, dcyc);
    checks++;
    if (dcyc < 0 || wr_q.size() != 256) begin
      errors++;
      $display("FAIL wrap_count: writes=%0d done_cyc=%0d required 256 writes",
               wr_q.size(), dcyc);
    end
    d = rd_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL wrap_reads: first bad idx %0d got n=%0d required n=%0d",
               d, rd_q.size(), exp_rd.size());
    end
    d = wr_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL wrap_writes: first bad idx %0d got n=%0d required n=%0d",
               d, wr_q.size(), exp_wr.size());
    end
    @(negedge clk);
  endtask

  task automatic test_vblank_drop();
    int dcyc, d, a0;
    bit en_seen;
    logic [15:0] b;
    ack_max = 0; lat_min = 1; lat_max = 1;
    vblank = 1'b1;
    b = 16'($urandom);
    clear_obs();
    build_exp(b, 9'd3, 3'b001);
    a0 = ack_count;
    pulse_start(b, 9'd3, 3'b001);
    for (int i = 0; i < 20; i++) begin
      if (ack_count != a0) break;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    vblank = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (src_read_en) en_seen = 1;
    end
    checks++;
    if (en_seen) begin
      errors++;
      $display("FAIL vb_no_req: src_read_en got 1 required 0 in blanking gap");
    end
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== exp_wr[0]) begin
      errors++;
      $display("FAIL vb_inflight: writes=%0d required 1 (id 0)",
               wr_q.size());
    end
    vblank = 1'b1;
    wait_done(100, dcyc);
    d = wr_diff();
    checks++;
    if (dcyc < 0 || d >= 0 || rd_diff() >= 0) begin
      errors++;
      $display("FAIL vb_resume: bad idx %0d writes=%0d done_cyc=%0d required 3 writes",
               d, wr_q.size(), dcyc);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int dcyc, d, k;
    logic [15:0] b;
    logic [8:0]  c;
    logic [2:0]  m;
    ack_max = 5; lat_min = 1; lat_max = 6;
    for (int t = 0; t < 4; t++) begin
      b = 16'($urandom);
      c = 9'($urandom_range(24, 4));
      m = 3'($urandom_range(7, 1));
      clear_obs();
      build_exp(b, c, m);
      vblank = 1'b1;
      pulse_start(b, c, m);
      k = int'($urandom_range(6, 1));
      dcyc = -1;
      for (int i = 0; i < 4000; i++) begin
        if (done) begin
          dcyc = cyc;
          break;
        end
        vblank = ($urandom_range(3, 0) != 0);
        start = (i == k);
        src_base_address = 16'($urandom);
        count = 9'($urandom);
        block_mask = 3'($urandom);
        @(negedge clk);
      end
      start = 1'b0;
      vblank = 1'b1;
      checks++;
      if (dcyc < 0 || dcyc != last_wr_cyc + 1) begin
        errors++;
        $display("FAIL rand_done[%0d]: done cyc %0d required %0d",
                 t, dcyc, last_wr_cyc + 1);
      end
      d = rd_diff();
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL rand_reads[%0d]: bad idx %0d got n=%0d required n=%0d",
                 t, d, rd_q.size(), exp_rd.size());
      end
      d = wr_diff();
      checks++;
      if (d >= 0) begin
        errors++;
        $display("FAIL rand_writes[%0d]: bad idx %0d got n=%0d required n=%0d",
                 t, d, wr_q.size(), exp_wr.size());
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int dcyc, d, a0;
    bit bad;
    ack_max = 0; lat_min = 6; lat_max = 6;
    vblank = 1'b1;
    clear_obs();
    a0 = ack_count;
    pulse_start(16'h1234, 9'd4, 3'b001);
    for (int i = 0; i < 20; i++) begin
      if (ack_count != a0) break;
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, done, src_read_en, src_read_address, meta_we,
         meta_address, meta_write_data, meta_block_select} !== '0) begin
      errors++;
      $display("FAIL rst_mid_values: busy=%b en=%b ra=%h we=%b ma=%h required all zero",
               busy, src_read_en, src_read_address, meta_we, meta_address);
    end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (meta_we || busy || src_read_en) bad = 1;
    end
    checks++;
    if (bad || wr_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: writes=%0d activity=%0d required 0 0",
               wr_q.size(), bad);
    end
    ack_max = 2; lat_min = 1; lat_max = 3;
    clear_obs();
    build_exp(16'h0F80, 9'd3, 3'b011);
    pulse_start(16'h0F80, 9'd3, 3'b011);
    wait_done(300, dcyc);
    d = wr_diff();
    checks++;
    if (dcyc < 0 || d >= 0 || rd_diff() >= 0) begin
      errors++;
      $display("FAIL rst_mid_restart: bad idx %0d writes=%0d required %0d",
               d, wr_q.size(), exp_wr.size());
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    vblank = 1'b0;
    src_base_address = '0;
    count = '0;
    block_mask = '0;
    test_reset();
    test_basic();
    test_zero_length();
    test_wrap_256();
    test_vblank_drop();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
